pr_ctrl_regs: RTL

SoftReg front end and round controller for the PageRank engine. It sits between the host SoftReg port and the PageRank datapath. It latches the run parameters written by the host, sequences `N_ROUNDS` rank iterations with ping-pong rank buffers, and answers the host's blocking `DONE_ALL` read with the final total sum.

---
 rtl/pr_ctrl_regs.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/pr_ctrl_regs.sv
// -----------------------------------------------------------------------------
// pr_ctrl_regs
//   SoftReg front end and round controller for the PageRank engine.
//   Latches the run parameters written by the host, sequences N_ROUNDS rank
//   iterations over ping-pong rank buffers, and answers the host's blocking
//   DONE_ALL read with the engine's final total sum.
//
// Optional feature macro:
//   PR_SOFTREG_READBACK_EN - when defined, reads of parameter addresses return
//                            the stored value; otherwise they return 0.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   softreg_req_*             host request: valid strobe, isWrite, addr, data
//   softreg_resp_valid/_data  registered one-cycle read response
//   n_vert, n_inedges,
//   vaddr, ieaddr             latched run parameters
//   src_addr, dst_addr        rank buffers read / written by the current round
//   round_start               one-cycle pulse starting a round
//   round_idx                 0-based index of the current round
//   round_done                engine pulse marking the end of a round
//   total_sum                 engine's final rank sum, returned by DONE_ALL
//   busy, all_done            status: START/RUN, DONE
//
// Register map (byte addresses on softreg_req_addr):
//   0x00 N_VERT       0x08 N_INEDGES    0x10 VADDR        0x18 IEADDR
//   0x20 WRITE_ADDR0  0x28 WRITE_ADDR1  0x30 N_ROUNDS
//   0x38 DONE_READ_PARAMS (write: start run)   0x40 DONE_ALL (blocking read)
// -----------------------------------------------------------------------------
module pr_ctrl_regs #(
  parameter int RW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          softreg_req_valid,
  input  logic          softreg_req_isWrite,
  input  logic [31:0]   softreg_req_addr,
  input  logic [63:0]   softreg_req_data,
  output logic          softreg_resp_valid,
  output logic [63:0]   softreg_resp_data,
  output logic [63:0]   n_vert,
  output logic [63:0]   n_inedges,
  output logic [63:0]   vaddr,
  output logic [63:0]   ieaddr,
  output logic [63:0]   src_addr,
  output logic [63:0]   dst_addr,
  output logic          round_start,
  output logic [RW-1:0] round_idx,
  input  logic          round_done,
  input  logic [63:0]   total_sum,
  output logic          busy,
  output logic          all_done
);

  localparam logic [31:0] ADDR_N_VERT      = 32'h00;
  localparam logic [31:0] ADDR_N_INEDGES   = 32'h08;
  localparam logic [31:0] ADDR_VADDR       = 32'h10;
  localparam logic [31:0] ADDR_IEADDR      = 32'h18;
  localparam logic [31:0] ADDR_WRITE_ADDR0 = 32'h20;
  localparam logic [31:0] ADDR_WRITE_ADDR1 = 32'h28;
  localparam logic [31:0] ADDR_N_ROUNDS    = 32'h30;
  localparam logic [31:0] ADDR_START       = 32'h38;
  localparam logic [31:0] ADDR_DONE_ALL    = 32'h40;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [63:0]   n_vert_q, n_vert_d;
  logic [63:0]   n_inedges_q, n_inedges_d;
  logic [63:0]   vaddr_q, vaddr_d;
  logic [63:0]   ieaddr_q, ieaddr_d;
  logic [63:0]   wr_addr0_q, wr_addr0_d;
  logic [63:0]   wr_addr1_q, wr_addr1_d;
  logic [63:0]   n_rounds_q, n_rounds_d;
  logic [RW-1:0] round_idx_q, round_idx_d;
  logic          pend_q, pend_d;
  logic          resp_valid_q, resp_valid_d;
  logic [63:0]   resp_data_q, resp_data_d;

  logic          req_wr, req_rd, req_done_all;
  logic [RW-1:0] round_nxt;
  logic [63:0]   rd_param;

  assign req_wr       = softreg_req_valid &  softreg_req_isWrite;
  assign req_rd       = softreg_req_valid & ~softreg_req_isWrite;
  assign req_done_all = (softreg_req_addr == ADDR_DONE_ALL);
  assign round_nxt    = round_idx_q + RW'(1);

  // Read data for non-DONE_ALL addresses.
  always_comb begin
    rd_param = '0;
`ifdef PR_SOFTREG_READBACK_EN
    case (softreg_req_addr)
      ADDR_N_VERT:      rd_param = n_vert_q;
      ADDR_N_INEDGES:   rd_param = n_inedges_q;
      ADDR_VADDR:       rd_param = vaddr_q;
      ADDR_IEADDR:      rd_param = ieaddr_q;
      ADDR_WRITE_ADDR0: rd_param = wr_addr0_q;
      ADDR_WRITE_ADDR1: rd_param = wr_addr1_q;
      ADDR_N_ROUNDS:    rd_param = n_rounds_q;
      default:          rd_param = '0;
    endcase
`else
    rd_param = '0;
`endif
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    n_vert_d     = n_vert_q;
    n_inedges_d  = n_inedges_q;
    vaddr_d      = vaddr_q;
    ieaddr_d     = ieaddr_q;
    wr_addr0_d   = wr_addr0_q;
    wr_addr1_d   = wr_addr1_q;
    n_rounds_d   = n_rounds_q;
    round_idx_d  = round_idx_q;
    pend_d       = pend_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;

    // Parameters are only writable in IDLE, which locks them during a run.
    if (state_q == S_IDLE && req_wr) begin
      case (softreg_req_addr)
        ADDR_N_VERT:      n_vert_d    = softreg_req_data;
        ADDR_N_INEDGES:   n_inedges_d = softreg_req_data;
        ADDR_VADDR:       vaddr_d     = softreg_req_data;
        ADDR_IEADDR:      ieaddr_d    = softreg_req_data;
        ADDR_WRITE_ADDR0: wr_addr0_d  = softreg_req_data;
        ADDR_WRITE_ADDR1: wr_addr1_d  = softreg_req_data;
        ADDR_N_ROUNDS:    n_rounds_d  = softreg_req_data;
        ADDR_START: begin
          round_idx_d = '0;
          state_d     = (n_rounds_q[RW-1:0] == '0) ? S_DONE : S_START;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (round_done) begin
          if (round_nxt == n_rounds_q[RW-1:0]) begin
            state_d = S_DONE;
          end else begin
            round_idx_d = round_nxt;
            state_d     = S_START;
          end
        end
      end
      S_DONE: begin
        // A DONE_ALL read parked before the run finished is answered now.
        if (pend_q) begin
          resp_valid_d = 1'b1;
          resp_data_d  = total_sum;
          pend_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: ;
    endcase

    // Single outstanding read: anything arriving while pend is set is dropped.
    if (req_rd && !pend_q) begin
      if (req_done_all) begin
        if (state_q == S_DONE) begin
          resp_valid_d = 1'b1;
          resp_data_d  = total_sum;
          state_d      = S_IDLE;
        end else begin
          pend_d = 1'b1;
        end
      end else begin
        resp_valid_d = 1'b1;
        resp_data_d  = rd_param;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      n_vert_q     <= '0;
      n_inedges_q  <= '0;
      vaddr_q      <= '0;
      ieaddr_q     <= '0;
      wr_addr0_q   <= '0;
      wr_addr1_q   <= '0;
      n_rounds_q   <= '0;
      round_idx_q  <= '0;
      pend_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      n_vert_q     <= n_vert_d;
      n_inedges_q  <= n_inedges_d;
      vaddr_q      <= vaddr_d;
      ieaddr_q     <= ieaddr_d;
      wr_addr0_q   <= wr_addr0_d;
      wr_addr1_q   <= wr_addr1_d;
      n_rounds_q   <= n_rounds_d;
      round_idx_q  <= round_idx_d;
      pend_q       <= pend_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign softreg_resp_valid = resp_valid_q;
  assign softreg_resp_data  = resp_data_q;
  assign n_vert             = n_vert_q;
  assign n_inedges          = n_inedges_q;
  assign vaddr              = vaddr_q;
  assign ieaddr             = ieaddr_q;
  assign round_idx          = round_idx_q;
  assign round_start        = (state_q == S_START);
  assign busy               = (state_q == S_START) || (state_q == S_RUN);
  assign all_done           = (state_q == S_DONE);

  // Even rounds read buffer 1 and write buffer 0; odd rounds swap.
  assign src_addr = round_idx_q[0] ? wr_addr0_q : wr_addr1_q;
  assign dst_addr = round_idx_q[0] ? wr_addr1_q : wr_addr0_q;

endmodule
